// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_VALID = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10
    } fault_cause_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry prefetch buffer: holds a single instruction word tagged with its address.
module fetch_buffer (
    input  logic        clk,
    input  logic        i_srst,
    input  logic        i_flush,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_tag,
    input  logic [31:0] i_wr_data,
    output logic        o_valid,
    output logic [31:0] o_tag,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [31:0] r_tag;
    logic [31:0] r_data;

    // Flush wins over a write so a consumed or discarded entry never reappears.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_wr_tag;
            r_data  <= i_wr_data;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: FETCH/VALID/FAULT sequencer with ack timeout and alignment checks.
// Optional one-entry next-line prefetch is enabled with the FETCH_PREFETCH_EN macro.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_new,
    input  logic        pc_load,
    output logic [31:0] curr_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    fetch_state_t r_state;
    fault_cause_t r_cause;
    logic [31:0]  r_curr_pc;
    logic [31:0]  r_instr;
    logic [7:0]   r_ack_cnt;

    logic         w_req;
    logic         w_timeout;
    logic [7:0]   w_cnt_inc;
    logic         w_demand_ack;
    logic         w_fast_hit;
    logic [31:0]  w_fast_data;

    assign w_cnt_inc = (r_ack_cnt == 8'hFF) ? 8'hFF : r_ack_cnt + 8'd1;
    assign w_timeout = w_cnt_inc >= TIMEOUT_CNT;

`ifdef FETCH_PREFETCH_EN
    logic [31:0] r_req_addr;
    logic        w_buf_valid;
    logic [31:0] w_buf_tag;
    logic [31:0] w_buf_data;
    logic        w_buf_hit;
    logic        w_pf_ack_hit;
    logic        w_buf_wr;
    logic        w_buf_flush;
    logic        w_pf_pending;

    // r_req_addr drives the bus in both states; in VALID it holds curr_pc+4.
    assign w_req        = !reset && ((r_state == ST_FETCH) ||
                                     ((r_state == ST_VALID) && !w_buf_valid));
    assign imem_addr    = r_req_addr;
    assign w_demand_ack = (r_req_addr == r_curr_pc);
    assign w_buf_hit    = w_buf_valid && (w_buf_tag == pc_new);
    assign w_pf_ack_hit = (r_state == ST_VALID) && w_req && imem_ack && (r_req_addr == pc_new);
    assign w_fast_hit   = w_buf_hit || w_pf_ack_hit;
    assign w_fast_data  = w_buf_hit ? w_buf_data : imem_rdata;
    assign w_buf_wr     = (r_state == ST_VALID) && w_req && imem_ack && !pc_load;
    assign w_buf_flush  = (r_state == ST_VALID) && pc_load;
    assign w_pf_pending = (r_state == ST_VALID) && w_req && !imem_ack;

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .i_srst    (reset),
        .i_flush   (w_buf_flush),
        .i_wr_en   (w_buf_wr),
        .i_wr_tag  (r_req_addr),
        .i_wr_data (imem_rdata),
        .o_valid   (w_buf_valid),
        .o_tag     (w_buf_tag),
        .o_data    (w_buf_data)
    );

    // An unacked prefetch keeps its address on the bus until it drains in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr <= RESET_PC;
        end else if ((r_state == ST_FETCH) && imem_ack) begin
            r_req_addr <= w_demand_ack ? r_curr_pc + INSTR_BYTES : r_curr_pc;
        end else if ((r_state == ST_VALID) && pc_load && is_word_aligned(pc_new[1:0])) begin
            if (w_fast_hit) begin
                r_req_addr <= pc_new + INSTR_BYTES;
            end else if (!w_pf_pending) begin
                r_req_addr <= pc_new;
            end
        end
    end
`else
    assign w_req        = !reset && (r_state == ST_FETCH);
    assign imem_addr    = r_curr_pc;
    assign w_demand_ack = 1'b1;
    assign w_fast_hit   = 1'b0;
    assign w_fast_data  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_cause   <= CAUSE_NONE;
            r_curr_pc <= RESET_PC;
            r_instr   <= '0;
            r_ack_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ack_cnt <= '0;
                        if (w_demand_ack) begin
                            r_instr <= imem_rdata;
                            r_state <= ST_VALID;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_ack_cnt <= w_cnt_inc;
                    end
                end
                ST_VALID: begin
                    if (pc_load) begin
                        if (!is_word_aligned(pc_new[1:0])) begin
                            r_state <= ST_FAULT;
                            r_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_curr_pc <= pc_new;
                            r_ack_cnt <= '0;
                            if (w_fast_hit) begin
                                r_instr <= w_fast_data;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end
                    end else if (w_req) begin
                        // Prefetch traffic in VALID obeys the same timeout.
                        if (imem_ack) begin
                            r_ack_cnt <= '0;
                        end else if (w_timeout) begin
                            r_state <= ST_FAULT;
                            r_cause <= CAUSE_TIMEOUT;
                        end else begin
                            r_ack_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign curr_pc     = r_curr_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_VALID);
    assign imem_req    = w_req;
    assign fault       = (r_state == ST_FAULT);
    assign fault_cause = r_cause;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit with a randomized behavioural memory/PC model.
module tb_mips_fetch_unit;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_new = '0;
    logic        pc_load = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] curr_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fault;
    logic [1:0]  fault_cause;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_pc = RST_PC;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .RESET_PC    (RST_PC),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_new      (pc_new),
        .pc_load     (pc_load),
        .curr_pc     (curr_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        x = {a[15:0] ^ 16'h2008, ~a[31:16]};
        return x + 32'h0000_0005;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        pc_load = 1'b0;
        imem_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_pc = RST_PC;
        #1;
    endtask

    task automatic issue_load(input logic [31:0] target);
        pc_load = 1'b1;
        pc_new = target;
        step();
        pc_load = 1'b0;
        model_pc = target;
    endtask

    // Waits `delay` unacked request cycles, then acks; checks bus and result.
    task automatic fetch_and_check(input logic [31:0] addr, input int delay, input bit noise);
        logic [31:0] w;
        w = mem_word(addr);
        for (int i = 0; i <= delay; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== addr || instr_valid !== 1'b0 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d]: req=%b addr=%h valid=%b fault=%b, expected req=1 addr=%h valid=0 fault=0",
                         i, imem_req, imem_addr, instr_valid, fault, addr);
            end
            imem_ack = (i == delay);
            imem_rdata = (i == delay) ? w : $urandom;
            pc_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            pc_new = $urandom;
            step();
        end
        imem_ack = 1'b0;
        pc_load = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== w || curr_pc !== addr || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_result: valid=%b instr=%h pc=%h fault=%b, expected valid=1 instr=%h pc=%h fault=0",
                     instr_valid, instr, curr_pc, fault, w, addr);
        end
`ifndef FETCH_PREFETCH_EN
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_no_req: req=%b, expected 0", imem_req);
        end
`endif
        $display("fetch addr=%h delay=%0d instr=%h", addr, delay, w);
    endtask

    // In prefetch builds, complete the pending next-line request so VALID is quiet.
    task automatic settle_prefetch();
`ifdef FETCH_PREFETCH_EN
        imem_ack = 1'b1;
        imem_rdata = mem_word(model_pc + 32'd4);
        step();
        imem_ack = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            step();
            n_checks++;
            if (curr_pc !== RST_PC || instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
                fault !== 1'b0 || fault_cause !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b fault=%b cause=%b, expected pc=%h instr=0 valid=0 req=0 fault=0 cause=00",
                         curr_pc, instr, instr_valid, imem_req, fault, fault_cause, RST_PC);
            end
        end
        imem_ack = 1'b0;
        reset = 1'b0;
        model_pc = RST_PC;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_request: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
        $display("reset released, first request at %h", RST_PC);
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || curr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_wait: valid=%b instr=%h pc=%h, expected valid=1 instr=20080005 pc=00000000",
                     instr_valid, instr, curr_pc);
        end
        $display("zero-wait fetch instr=%h", instr);
    endtask

    task automatic test_delayed_ack();
        issue_load(32'h0000_0100);
        fetch_and_check(32'h0000_0100, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] target;
        logic [31:0] rnd;
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                pc_new = $urandom;
                step();
                n_checks++;
                if (instr_valid !== 1'b1 || instr !== mem_word(model_pc) || curr_pc !== model_pc || imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_hold: valid=%b instr=%h pc=%h req=%b, expected valid=1 instr=%h pc=%h req=0",
                             instr_valid, instr, curr_pc, imem_req, mem_word(model_pc), model_pc);
                end
            end
            rnd = $urandom;
            rnd[1:0] = 2'b00;
            case ($urandom_range(0, 3))
                0: target = model_pc + 32'd4;
                1: target = rnd;
                2: target = 32'hFFFF_FFFC;
                default: target = model_pc;
            endcase
            issue_load(target);
            fetch_and_check(target, int'($urandom_range(0, 3)), 1'b1);
        end
        issue_load(32'hFFFF_FFFC);
        fetch_and_check(32'hFFFF_FFFC, 0, 1'b0);
        issue_load(model_pc + 32'd4);
        fetch_and_check(32'h0000_0000, 1, 1'b0);
    endtask

    task automatic test_misaligned();
        reset_dut();
        fetch_and_check(RST_PC, 0, 1'b0);
        settle_prefetch();
        issue_load(32'h0000_0080);
        fetch_and_check(32'h0000_0080, 2, 1'b0);
        pc_load = 1'b1;
        pc_new = 32'h0000_0102;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fault !== 1'b1 || fault_cause !== 2'b01 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                curr_pc !== 32'h0000_0080) begin
                n_fail++;
                $display("FAIL misalign[%0d]: fault=%b cause=%b req=%b valid=%b pc=%h, expected fault=1 cause=01 req=0 valid=0 pc=00000080",
                         i, fault, fault_cause, imem_req, instr_valid, curr_pc);
            end
            pc_load = 1'b1;
            pc_new = 32'h0000_0200;
            imem_ack = 1'b1;
            step();
        end
        pc_load = 1'b0;
        imem_ack = 1'b0;
        $display("misaligned pc_new=00000102 -> fault cause=%b", fault_cause);
    endtask

    task automatic test_timeout();
        reset_dut();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: req=%b fault=%b, expected req=1 fault=0", i, imem_req, fault);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fault !== 1'b1 || fault_cause !== 2'b10 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
                n_fail++;
                $display("FAIL timeout_fault[%0d]: fault=%b cause=%b req=%b valid=%b instr=%h, expected fault=1 cause=10 req=0 valid=0 instr=0",
                         i, fault, fault_cause, imem_req, instr_valid, instr);
            end
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            step();
        end
        imem_ack = 1'b0;
        $display("timeout after %0d request cycles -> cause=%b", TIMEOUT, fault_cause);
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        fetch_and_check(RST_PC, 0, 1'b0);
        settle_prefetch();
        issue_load(32'h0000_0200);
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL midflight_req: req=%b addr=%h, expected req=1 addr=00000200", imem_req, imem_addr);
        end
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        step();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || curr_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL midflight_reset: req=%b valid=%b instr=%h pc=%h, expected req=0 valid=0 instr=0 pc=%h",
                     imem_req, instr_valid, instr, curr_pc, RST_PC);
        end
        imem_ack = 1'b0;
        reset = 1'b0;
        model_pc = RST_PC;
        #1;
        fetch_and_check(RST_PC, 1, 1'b0);
        $display("reset mid-transaction, refetch at %h", RST_PC);
    endtask

`ifdef FETCH_PREFETCH_EN
    task automatic test_prefetch();
        reset_dut();
        fetch_and_check(RST_PC, 0, 1'b0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd4) begin
            n_fail++;
            $display("FAIL pf_request: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RST_PC + 32'd4);
        end
        imem_ack = 1'b1;
        imem_rdata = mem_word(RST_PC + 32'd4);
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== mem_word(RST_PC)) begin
            n_fail++;
            $display("FAIL pf_full: req=%b valid=%b instr=%h, expected req=0 valid=1 instr=%h",
                     imem_req, instr_valid, instr, mem_word(RST_PC));
        end
        issue_load(RST_PC + 32'd4);
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== mem_word(RST_PC + 32'd4) || curr_pc !== RST_PC + 32'd4 ||
            imem_addr !== RST_PC + 32'd8) begin
            n_fail++;
            $display("FAIL pf_hit: valid=%b instr=%h pc=%h addr=%h, expected valid=1 instr=%h pc=%h addr=%h",
                     instr_valid, instr, curr_pc, imem_addr, mem_word(RST_PC + 32'd4), RST_PC + 32'd4, RST_PC + 32'd8);
        end
        settle_prefetch();
        issue_load(32'h0000_0040);
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL pf_branch: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000040",
                     instr_valid, imem_req, imem_addr);
        end
        fetch_and_check(32'h0000_0040, 1, 1'b0);
        $display("prefetch hit and branch flush checked");
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
`ifdef FETCH_PREFETCH_EN
        test_prefetch();
`else
        test_delayed_ack();
        test_back_to_back();
`endif
        test_misaligned();
        test_timeout();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ACK_TIMEOUT, default 255, max consecutive unacknowledged request cycles (1..255).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc_new  in  32  next PC computed by the core.
REQ-006 pc_load  in  1  core consumes current instruction and commits pc_new.
REQ-007 curr_pc  out  32  address of the instruction presented on instr.
REQ-008 instr  out  32  fetched instruction word.
REQ-009 instr_valid  out  1  instr/curr_pc are valid for the core.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  32  request address, word aligned.
REQ-012 imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  in  32  read data, sampled only when imem_req && imem_ack.
REQ-014 fault  out  1  sticky fetch fault.
REQ-015 fault_cause  out  2  00 none, 01 misaligned pc_new, 10 ack timeout.

Function
REQ-016 The FSM SHALL have states FETCH (request outstanding), VALID (instruction held), FAULT (halted).
REQ-017 In FETCH, imem_req SHALL be 1 with imem_addr stable until the cycle imem_ack=1; a same-cycle ack is legal (zero-wait memory).
REQ-018 On the ack edge, instr SHALL capture imem_rdata and the state SHALL become VALID, so instr_valid rises one cycle after ack.
REQ-019 In VALID with pc_load=1 and pc_new[1:0]==0, curr_pc SHALL load pc_new, instr_valid SHALL drop, and the state SHALL return to FETCH.
REQ-020 pc_load while instr_valid=0 SHALL be ignored.
REQ-021 pc_load with pc_new[1:0]!=0 SHALL enter FAULT with fault_cause=01, and curr_pc SHALL remain unchanged.
REQ-022 A saturating 8-bit counter SHALL count consecutive FETCH cycles without ack; reaching ACK_TIMEOUT SHALL enter FAULT with fault_cause=10.
REQ-023 The counter SHALL clear on every ack and on every entry to FETCH.
REQ-024 In FAULT, imem_req=0 and instr_valid=0, and only reset SHALL exit.
REQ-025 pc_new+4 style arithmetic SHALL be 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0 without fault.

Reset
REQ-026 While reset=1: curr_pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, fault_cause=00, counter=0, prefetch buffer empty.
REQ-027 imem_ack during reset SHALL be ignored.
REQ-028 The first cycle after reset release SHALL be FETCH with imem_addr=RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction, with imem_req low from the next edge.

Configuration
REQ-030 Macro FETCH_PREFETCH_EN SHALL enable a one-entry next-line prefetch.
REQ-031 With the macro, in VALID the unit SHALL request curr_pc+4 and store the result in the buffer.
REQ-032 With the macro, on pc_load with pc_new==curr_pc+4 and the buffer full, the unit SHALL go directly to VALID next cycle with the buffered word (no memory cycle).
REQ-033 With the macro, on pc_load with any other target, the unit SHALL discard the buffer.
REQ-034 An outstanding prefetch SHALL complete (ack consumed, data dropped if unneeded) before a new request issues.
REQ-035 Prefetch requests SHALL be subject to the same timeout.
REQ-036 Without the macro, the unit SHALL make no request in VALID and SHALL include no buffer logic.

Structure
REQ-037 Package mips_pkg SHALL hold the fetch state enum, the fault_cause codes, and the default RESET_PC.
REQ-038 Sub-module fetch_buffer (one-entry word+tag register with valid/flush) SHALL be instantiated only under FETCH_PREFETCH_EN.

Verification
REQ-039 Reset release with ack same cycle as req and rdata=32'h2008_0005 -> instr_valid=1 next cycle, instr=32'h2008_0005, curr_pc=0.
REQ-040 Ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr constant, and instr_valid stays 0 until the cycle after ack.
REQ-041 pc_load with pc_new=32'h0000_0102 -> fault=1, fault_cause=01, imem_req=0, curr_pc unchanged.
REQ-042 ACK_TIMEOUT=4 with ack never asserted -> fault_cause=10 after 4 request cycles, and subsequent ack is ignored.
REQ-043 FETCH_PREFETCH_EN, sequential pc_load curr_pc+4 with buffer full -> instr_valid=1 next cycle with no imem_req; branch to 32'h40 -> buffer flushed, imem_addr=32'h40.
REQ-044 Reset asserted during outstanding request -> imem_req=0 next cycle, and the first post-reset request addresses RESET_PC.
